// File: rtl/jtframe_prog_pkg.sv
// Shared types for the prog packer: collector FSM states, FIFO entry layout, lane helper.
// Entry fields are sized for the widest legal configuration; narrower builds use the low bits.
package jtframe_prog_pkg;

    localparam int MAX_AW = 32;
    localparam int MAX_DW = 32;
    localparam int MAX_NB = MAX_DW / 8;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        FLUSH
    } prog_state_t;

    typedef struct packed {
        logic [MAX_AW-1:0] addr;
        logic [MAX_DW-1:0] data;
        logic [MAX_NB-1:0] mask;
    } prog_entry_t;

    function automatic int prog_lanes(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/jtframe_prog_fifo.sv
// Entry FIFO between the byte collector and the prog output stage; zero-latency head view.
// Push while full and pop while empty are ignored, so the count can never leave 0..DEPTH.
module jtframe_prog_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [W-1:0]             i_dat,
    input  logic                     i_pop,
    output logic [W-1:0]             o_dat,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [PW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == (PW+1)'(DEPTH));
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dat   = r_mem[r_rp];
    assign o_count = r_cnt;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= i_dat;
    end

    // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH by themselves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + PW'(1);
            if (w_pop)  r_rp <= r_rp + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/jtframe_prog_packer.sv
// Packs the ioctl byte stream into masked prog word writes, with region remap; min 2-cycle latency.
// ioctl_wait rises at FIFO_DEPTH-1 queued entries or while flushing; optional JTFRAME_PROG_SWAP_EN byte swap.
module jtframe_prog_packer
    import jtframe_prog_pkg::*;
#(
    parameter int AW         = 22,
    parameter int DW         = 16,
    parameter int PACK       = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int REGIONS    = 1
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  downloading,
    input  logic [AW-1:0]         ioctl_addr,
    input  logic [7:0]            ioctl_data,
    input  logic                  ioctl_wr,
    output logic                  ioctl_wait,
    input  logic [REGIONS*AW-1:0] region_start,
    input  logic [REGIONS*AW-1:0] region_offset,
`ifdef JTFRAME_PROG_SWAP_EN
    input  logic [REGIONS-1:0]    region_swap,
`endif
    output logic [AW-1:0]         prog_addr,
    output logic [DW-1:0]         prog_data,
    output logic [DW/8-1:0]       prog_mask,
    output logic                  prog_we,
    input  logic                  prog_rdy
);
    localparam int NB = prog_lanes(DW);
    localparam int LB = $clog2(NB);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    prog_state_t r_state, w_state_nxt;
    logic [DW-1:0] r_col_data;
    logic [NB-1:0] r_col_mask;
    logic [AW-1:0] r_col_addr;
    logic [1:0]    r_col_region;
    logic          r_pend;
    logic          r_overrun;

    logic [1:0]    w_region;
    logic          w_swap;
    logic [AW-1:0] w_waddr;
    logic [LB-1:0] w_lane_raw, w_lane;
    logic          w_top;
    logic [DW-1:0] w_byte_data;
    logic [NB-1:0] w_byte_mask;
    logic          w_stb, w_nonempty, w_change, w_old_push;
    logic          w_push, w_pop, w_empty, w_full;
    logic [CW-1:0] w_cnt;
    logic [AW-1:0] w_ent_addr;
    logic [DW-1:0] w_ent_data;
    logic [NB-1:0] w_ent_mask;
    prog_entry_t   w_push_ent, w_head;

    // Ascending scan: the last start that is <= the address wins, i.e. the highest index.
    always_comb begin
        w_region = '0;
        w_swap   = 1'b0;
        for (int k = 1; k < REGIONS; k++)
            if (ioctl_addr >= region_start[k*AW +: AW]) w_region = 2'(k);
`ifdef JTFRAME_PROG_SWAP_EN
        for (int k = 0; k < REGIONS; k++)
            if (w_region == 2'(k)) w_swap = region_swap[k];
`endif
    end

    assign w_waddr     = (ioctl_addr >> LB) + region_offset[int'(w_region)*AW +: AW];
    assign w_lane_raw  = ioctl_addr[LB-1:0];
    assign w_top       = &w_lane_raw;
    assign w_lane      = w_swap ? ~w_lane_raw : w_lane_raw;
    assign w_byte_data = DW'(ioctl_data) << (8 * w_lane);
    assign w_byte_mask = ~(NB'(1) << w_lane);

    assign w_stb      = ioctl_wr && (r_state != FLUSH) && !w_full;
    assign w_nonempty = ~&r_col_mask;
    assign w_change   = (w_waddr != r_col_addr) || (w_region != r_col_region);
    // The collected partial word leaves ahead of any new byte: on a word/region change,
    // on a deferred lone top-lane byte, or when the download window closes.
    assign w_old_push = (PACK != 0) && w_nonempty && !w_full &&
                        (r_pend || (r_state == FLUSH) || (w_stb && w_change));

    always_comb begin
        w_push     = 1'b0;
        w_ent_addr = r_col_addr;
        w_ent_data = r_col_data;
        w_ent_mask = r_col_mask;
        if (PACK == 0) begin
            w_push     = w_stb;
            w_ent_addr = w_waddr;
            w_ent_data = w_byte_data;
            w_ent_mask = w_byte_mask;
        end else if (w_old_push) begin
            w_push = 1'b1;
        end else if (w_stb && w_top) begin
            w_push     = 1'b1;
            w_ent_addr = w_waddr;
            w_ent_data = r_col_data | w_byte_data;
            w_ent_mask = r_col_mask & w_byte_mask;
        end
        w_push_ent.addr = MAX_AW'(w_ent_addr);
        w_push_ent.data = MAX_DW'(w_ent_data);
        w_push_ent.mask = MAX_NB'(w_ent_mask);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_stb) w_state_nxt = COLLECT;
            COLLECT: if (!downloading) w_state_nxt = FLUSH;
            FLUSH:   if (!w_nonempty || w_old_push) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_col_data   <= '0;
            r_col_mask   <= '1;
            r_col_addr   <= '0;
            r_col_region <= '0;
            r_pend       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_overrun <= r_overrun | (ioctl_wr && (r_state != FLUSH) && w_full);
            if (PACK != 0) begin
                if (w_old_push || (w_stb && w_top)) begin
                    // A lone top-lane byte after a change is pushed next cycle via r_pend.
                    r_col_data <= (w_old_push && w_stb) ? w_byte_data : '0;
                    r_col_mask <= (w_old_push && w_stb) ? w_byte_mask : '1;
                    r_pend     <= w_old_push && w_stb && w_top;
                end else if (w_stb) begin
                    r_col_data <= r_col_data | w_byte_data;
                    r_col_mask <= r_col_mask & w_byte_mask;
                end
                if (w_stb) begin
                    r_col_addr   <= w_waddr;
                    r_col_region <= w_region;
                end
            end
        end
    end

    assign ioctl_wait = (w_cnt >= CW'(FIFO_DEPTH - 1)) || (r_state == FLUSH) || r_pend;

    jtframe_prog_fifo #(
        .W     ($bits(prog_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_dat   (w_push_ent),
        .i_pop   (w_pop),
        .o_dat   (w_head),
        .o_count (w_cnt),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // Output registers only reload when idle or accepted, keeping them stable under backpressure.
    assign w_pop = !w_empty && (!prog_we || prog_rdy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_we   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
            prog_mask <= '1;
        end else if (!prog_we || prog_rdy) begin
            prog_we <= !w_empty;
            if (!w_empty) begin
                prog_addr <= w_head.addr[AW-1:0];
                prog_data <= w_head.data[DW-1:0];
                prog_mask <= w_head.mask[NB-1:0];
            end
        end
    end

endmodule

// File: tb/tb_jtframe_prog_packer.sv
// Directed bench: three packer instances (16-bit unpacked, 32-bit packed, 16-bit packed with two regions).
module tb_jtframe_prog_packer;
    localparam int AW = 22;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          downloading = 1'b0;
    logic [AW-1:0] ioctl_addr = '0;
    logic [7:0]    ioctl_data = '0;
    logic [2:0]    wr = '0;
    logic [2:0]    rdy = 3'b111;
    logic [2:0]    wait_o;

    logic [AW-1:0] a_addr, b_addr, c_addr;
    logic [15:0]   a_data, c_data;
    logic [31:0]   b_data;
    logic [1:0]    a_mask, c_mask;
    logic [3:0]    b_mask;
    logic          a_we, b_we, c_we;
    logic [2*AW-1:0] c_start  = {22'h100, 22'h0};
    logic [2*AW-1:0] c_offset = {22'h8000, 22'h0};
    logic [1:0]    c_swap = 2'b00;

    logic [AW-1:0] qb_addr[$], qc_addr[$];
    logic [31:0]   qb_data[$];
    logic [15:0]   qc_data[$];
    logic [3:0]    qb_mask[$];
    logic [1:0]    qc_mask[$];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    jtframe_prog_packer #(.AW(AW), .DW(16), .PACK(0), .FIFO_DEPTH(4), .REGIONS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(wr[0]), .ioctl_wait(wait_o[0]),
        .region_start('0), .region_offset('0),
`ifdef JTFRAME_PROG_SWAP_EN
        .region_swap(1'b0),
`endif
        .prog_addr(a_addr), .prog_data(a_data), .prog_mask(a_mask), .prog_we(a_we), .prog_rdy(rdy[0])
    );

    jtframe_prog_packer #(.AW(AW), .DW(32), .PACK(1), .FIFO_DEPTH(4), .REGIONS(1)) u_b (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(wr[1]), .ioctl_wait(wait_o[1]),
        .region_start('0), .region_offset('0),
`ifdef JTFRAME_PROG_SWAP_EN
        .region_swap(1'b0),
`endif
        .prog_addr(b_addr), .prog_data(b_data), .prog_mask(b_mask), .prog_we(b_we), .prog_rdy(rdy[1])
    );

    jtframe_prog_packer #(.AW(AW), .DW(16), .PACK(1), .FIFO_DEPTH(4), .REGIONS(2)) u_c (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(wr[2]), .ioctl_wait(wait_o[2]),
        .region_start(c_start), .region_offset(c_offset),
`ifdef JTFRAME_PROG_SWAP_EN
        .region_swap(c_swap),
`endif
        .prog_addr(c_addr), .prog_data(c_data), .prog_mask(c_mask), .prog_we(c_we), .prog_rdy(rdy[2])
    );

    always @(posedge clk) begin
        if (b_we && rdy[1]) begin
            qb_addr.push_back(b_addr);
            qb_data.push_back(b_data);
            qb_mask.push_back(b_mask);
        end
        if (c_we && rdy[2]) begin
            qc_addr.push_back(c_addr);
            qc_data.push_back(c_data);
            qc_mask.push_back(c_mask);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int sel, input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        ioctl_addr = a;
        ioctl_data = d;
        wr[sel] = 1'b1;
        @(negedge clk);
        wr[sel] = 1'b0;
    endtask

    initial begin
        int sent;
        logic [7:0] b0;

        repeat (3) @(negedge clk);
        check("rst_we", b_we, 0);
        check("rst_addr", b_addr, 0);
        check("rst_data", b_data, 0);
        check("rst_mask32", b_mask, 4'hF);
        check("rst_mask16", a_mask, 2'b11);
        check("rst_wait", wait_o, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);
        downloading = 1'b1;

        // Unpacked 16-bit: one write per byte, with 2-cycle latency
        send(0, 22'h0, 8'h12);
        check("p0_latency_we0", a_we, 0);
        @(negedge clk);
        check("p0_w0_we", a_we, 1);
        check("p0_w0_addr", a_addr, 0);
        check("p0_w0_data", a_data, 16'h0012);
        check("p0_w0_mask", a_mask, 2'b10);
        send(0, 22'h1, 8'h34);
        @(negedge clk);
        check("p0_w1_we", a_we, 1);
        check("p0_w1_addr", a_addr, 0);
        check("p0_w1_data", a_data, 16'h3400);
        check("p0_w1_mask", a_mask, 2'b01);

        // Packed 32-bit full word
        send(1, 22'h0, 8'h11);
        send(1, 22'h1, 8'h22);
        send(1, 22'h2, 8'h33);
        send(1, 22'h3, 8'h44);
        check("p1_latency_we0", b_we, 0);
        @(negedge clk);
        check("p1_we", b_we, 1);
        repeat (3) @(negedge clk);
        check("p1_count", qb_data.size(), 1);
        check("p1_addr", qb_addr[0], 0);
        check("p1_data", qb_data[0], 32'h44332211);
        check("p1_mask", qb_mask[0], 4'b0000);

        // Two regions, partial word pushed on region change
        send(2, 22'h0FE, 8'h77);
        send(2, 22'h100, 8'h5A);
        send(2, 22'h101, 8'hC3);
        repeat (4) @(negedge clk);
        check("rg_count", qc_data.size(), 2);
        check("rg_part_addr", qc_addr[0], 22'h7F);
        check("rg_part_data", qc_data[0][7:0], 8'h77);
        check("rg_part_mask", qc_mask[0], 2'b10);
        check("rg1_addr", qc_addr[1], 22'h8080);
        check("rg1_data", qc_data[1], 16'hC35A);
        check("rg1_mask", qc_mask[1], 2'b00);

        // Flush of a partial word when downloading falls
        send(1, 22'h4, 8'h55);
        send(1, 22'h5, 8'h66);
        @(negedge clk);
        downloading = 1'b0;
        @(negedge clk);
        check("fl_wait_hi", wait_o[1], 1);
        @(negedge clk);
        check("fl_wait_lo", wait_o[1], 0);
        repeat (3) @(negedge clk);
        check("fl_count", qb_data.size(), 2);
        check("fl_addr", qb_addr[1], 1);
        check("fl_data", qb_data[1][15:0], 16'h6655);
        check("fl_mask", qb_mask[1], 4'b1100);

        // Backpressure: prog_rdy low for 20 cycles while the source honours ioctl_wait
        @(negedge clk);
        downloading = 1'b1;
        rdy[1] = 1'b0;
        sent = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (!wait_o[1] && sent < 24) begin
                ioctl_addr = AW'(8 + sent);
                ioctl_data = 8'(8'hA0 + sent);
                wr[1] = 1'b1;
                sent++;
            end else begin
                wr[1] = 1'b0;
            end
        end
        @(negedge clk);
        wr[1] = 1'b0;
        check("bp_sent", sent, 16);
        check("bp_wait", wait_o[1], 1);
        check("bp_we_held", b_we, 1);
        check("bp_addr_held", b_addr, 2);
        check("bp_data_held", b_data, 32'hA3A2A1A0);
        check("bp_no_accept", qb_data.size(), 2);
        rdy[1] = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (!wait_o[1] && sent < 24) begin
                ioctl_addr = AW'(8 + sent);
                ioctl_data = 8'(8'hA0 + sent);
                wr[1] = 1'b1;
                sent++;
            end else begin
                wr[1] = 1'b0;
            end
        end
        @(negedge clk);
        wr[1] = 1'b0;
        repeat (6) @(negedge clk);
        check("bp_total", qb_data.size(), 8);
        for (int j = 0; j < 6; j++) begin
            b0 = 8'hA0 + 8'(4 * j);
            check("bp_order_addr", qb_addr[2+j], 64'(2 + j));
            check("bp_order_data", qb_data[2+j], {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
            check("bp_order_mask", qb_mask[2+j], 4'b0000);
        end

`ifdef JTFRAME_PROG_SWAP_EN
        c_swap = 2'b01;
        send(2, 22'h0, 8'hAA);
        send(2, 22'h1, 8'hBB);
        repeat (4) @(negedge clk);
        check("sw_count", qc_data.size(), 3);
        check("sw_addr", qc_addr[2], 0);
        check("sw_data", qc_data[2], 16'hAABB);
        check("sw_mask", qc_mask[2], 2'b00);
        c_swap = 2'b00;
`endif

        // Reset during a download discards queued and partial data
        rdy[1] = 1'b0;
        send(1, 22'h40, 8'h01);
        send(1, 22'h41, 8'h02);
        send(1, 22'h42, 8'h03);
        send(1, 22'h43, 8'h04);
        send(1, 22'h44, 8'h05);
        @(negedge clk);
        check("mr_pre_we", b_we, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mr_we", b_we, 0);
        check("mr_mask", b_mask, 4'hF);
        check("mr_wait", wait_o[1], 0);
        rst_n = 1'b1;
        rdy[1] = 1'b1;
        downloading = 1'b0;
        repeat (8) @(negedge clk);
        check("mr_no_write", qb_data.size(), 8);
        check("mr_we_idle", b_we, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
